// File: rtl/bn_relu_arb.sv
// rtl/bn_relu_arb.sv - round-robin arbiter sharing one BN/ReLU datapath across requesters
// Grants bursts, issues beats with per-requester coefficients, routes results back by tag.
module bn_relu_arb #(
   parameter int NO_REQ    = 2,
   parameter int NO_CH     = 10,
   parameter int BW        = 12,
   parameter int R_SHIFT   = 6,
   parameter int LAT       = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [NO_REQ-1:0]                             req_vld,
   output logic [NO_REQ-1:0]                             req_rdy,
   input  logic [NO_REQ-1:0][NO_CH-1:0][BW-1:0]          req_data,
   input  logic [NO_REQ-1:0][NO_CH-1:0][BW+R_SHIFT-1:0]  coef_a,
   input  logic [NO_REQ-1:0][NO_CH-1:0][BW+R_SHIFT-1:0]  coef_b,
   output logic                                          dp_vld_in,
   output logic [NO_CH-1:0][BW-1:0]                      dp_data_in,
   output logic [NO_CH-1:0][BW+R_SHIFT-1:0]              dp_a,
   output logic [NO_CH-1:0][BW+R_SHIFT-1:0]              dp_b,
   input  logic                                          dp_vld_out,
   input  logic [NO_CH-1:0][BW-1:0]                      dp_data_out,
   output logic [NO_REQ-1:0]                             rsp_vld,
   output logic [NO_CH-1:0][BW-1:0]                      rsp_data,
   output logic                                          err
);

   localparam int IDW = (NO_REQ > 1) ? $clog2(NO_REQ) : 1;
   localparam int CW  = $clog2(MAX_BURST + 1);
   localparam int DW  = $clog2(LAT + 2);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                    state, state_nxt;
   logic [IDW-1:0]            gnt_id, last_id, pick_id, idx, iss_id;
   logic                      pick_vld;
   logic [CW-1:0]             cnt;
   logic                      xfer;
   logic [LAT-1:0]            tag_vld;
   logic [LAT-1:0][IDW-1:0]   tag_id;
   logic [DW-1:0]             drain;
   logic                      tag_hit;

   // Search from last_id+1 with wrap; iterate downwards so the nearest index wins.
   always_comb begin
      pick_id  = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int k = NO_REQ; k >= 1; k--) begin
         idx = IDW'((int'(last_id) + k) % NO_REQ);
         if (req_vld[idx]) begin
            pick_id  = idx;
            pick_vld = 1'b1;
         end
      end
   end

   assign xfer = (state == BURST) && req_vld[gnt_id];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         gnt_id  <= '0;
         last_id <= IDW'(NO_REQ - 1);
         cnt     <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_vld) begin
            gnt_id  <= pick_id;
            last_id <= pick_id;
            cnt     <= '0;
         end else if (xfer) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_vld) state_nxt = BURST;
         BURST:   if (!req_vld[gnt_id] || cnt == CW'(MAX_BURST - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_rdy = '0;
      if (state == BURST) req_rdy[gnt_id] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dp_vld_in  <= 1'b0;
         iss_id     <= '0;
         dp_data_in <= '0;
         dp_a       <= '0;
         dp_b       <= '0;
      end else begin
         dp_vld_in <= xfer;
         if (xfer) begin
            iss_id     <= gnt_id;
            dp_data_in <= req_data[gnt_id];
            dp_a       <= coef_a[gnt_id];
            dp_b       <= coef_b[gnt_id];
         end
      end
   end

   // Tag pipe mirrors the datapath so its last stage lines up with dp_vld_out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         tag_vld[0] <= dp_vld_in;
         tag_id[0]  <= iss_id;
         for (int s = 1; s < LAT; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_id[s]  <= tag_id[s-1];
         end
      end
   end

   assign tag_hit = dp_vld_out && tag_vld[LAT-1];

   // Mismatch checking stays masked while the datapath drains after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drain    <= DW'(LAT + 1);
         rsp_vld  <= '0;
         rsp_data <= '0;
         err      <= 1'b0;
      end else begin
         if (drain != '0) drain <= drain - DW'(1);
         rsp_vld <= '0;
         if (tag_hit) begin
            rsp_vld[tag_id[LAT-1]] <= 1'b1;
            rsp_data               <= dp_data_out;
         end
         if (drain == '0 && (dp_vld_out != tag_vld[LAT-1])) err <= 1'b1;
      end
   end

endmodule
